// File: rtl/ascii_hex_entry_if.sv
// Character-stream and committed-value handshake bundle for ascii_hex_entry.
// The master side is the keyboard front end plus the value consumer; the
// slave side is the entry block itself.
interface ascii_hex_entry_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic [7:0]   char_in;
    logic         char_valid;
    logic         char_ready;
    logic [W-1:0] partial;
    logic [3:0]   digit_count;
    logic [W-1:0] value;
    logic         value_valid;
    logic         value_ready;
    logic         err;

    modport master (
        output char_in, char_valid, value_ready,
        input  char_ready, partial, digit_count, value, value_valid, err
    );

    modport slave (
        input  char_in, char_valid, value_ready,
        output char_ready, partial, digit_count, value, value_valid, err
    );
endinterface

// File: rtl/ascii_hex_entry.sv
// ascii_hex_entry: assembles typed ASCII hex digits into a binary value.
// Hex digits shift into a right-justified accumulator. Backspace drops the
// newest digit, Escape clears the entry, and Enter commits a non-empty entry
// and holds it until the consumer takes it. Rejected characters raise a
// one-cycle err pulse.
module ascii_hex_entry #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    ascii_hex_entry_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_ENTER = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t       state;
    logic         is_hex;
    logic [3:0]   nib;
    logic         accept;
    logic         full;
    logic         empty;

    // Characters are taken only in COLLECT and never while reset is held.
    assign bus.char_ready = (state == COLLECT) && !rst;
    assign accept         = bus.char_valid && bus.char_ready;
    assign full           = (bus.digit_count == 4'(DIGITS));
    assign empty          = (bus.digit_count == 4'd0);

    // Map the incoming ASCII code to a hex nibble and flag whether it is a hex digit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        is_hex = 1'b0;
        nib    = 4'd0;
        if (bus.char_in >= 8'h30 && bus.char_in <= 8'h39) begin
            is_hex = 1'b1;
            nib    = bus.char_in[3:0];
        end else if ((bus.char_in >= 8'h41 && bus.char_in <= 8'h46) ||
                     (bus.char_in >= 8'h61 && bus.char_in <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = bus.char_in[3:0] + 4'd9;
        end
    end

    // Entry FSM: accumulator, digit counter, commit register and error pulse.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state           <= COLLECT;
            bus.partial     <= '0;
            bus.digit_count <= 4'd0;
            bus.value       <= '0;
            bus.value_valid <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (is_hex) begin
                            if (!full) begin
                                bus.partial     <= (bus.partial << 4) | W'(nib);
                                bus.digit_count <= bus.digit_count + 4'd1;
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end else if (bus.char_in == CH_BS) begin
                            if (!empty) begin
                                bus.partial     <= bus.partial >> 4;
                                bus.digit_count <= bus.digit_count - 4'd1;
                            end
                        end else if (bus.char_in == CH_ESC) begin
                            bus.partial     <= '0;
                            bus.digit_count <= 4'd0;
                        end else if (bus.char_in == CH_ENTER) begin
                            if (!empty) begin
                                bus.value       <= bus.partial;
                                bus.value_valid <= 1'b1;
                                bus.partial     <= '0;
                                bus.digit_count <= 4'd0;
                                state           <= HOLD;
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // value stays put; only the handshake releases it.
                    if (bus.value_ready) begin
                        bus.value_valid <= 1'b0;
                        state           <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_hex_entry.sv
// Self-checking bench for ascii_hex_entry (DIGITS=4): a table of per-cycle
// vectors plus hand-written sequences for HOLD back-pressure and reset.
module tb_ascii_hex_entry;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ascii_hex_entry_if #(.DIGITS(DIGITS)) bus ();

    ascii_hex_entry #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   ch;
        logic         valid;
        logic         vready;
        logic [W-1:0] exp_partial;
        logic [3:0]   exp_count;
        logic         exp_err;
        logic         exp_vv;
        logic [W-1:0] exp_value;
        logic         exp_cr;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [7:0] ch, input logic valid, input logic vready,
                               input logic [W-1:0] p, input logic [3:0] c, input logic e,
                               input logic vv, input logic [W-1:0] val, input logic cr);
        vec_t t;
        t.ch = ch; t.valid = valid; t.vready = vready;
        t.exp_partial = p; t.exp_count = c; t.exp_err = e;
        t.exp_vv = vv; t.exp_value = val; t.exp_cr = cr;
        return t;
    endfunction

    task automatic check_all(input string tag, input logic [W-1:0] p, input logic [3:0] c,
                             input logic e, input logic vv, input logic [W-1:0] val,
                             input logic cr);
        check({tag, " partial"},     32'(bus.partial),     32'(p));
        check({tag, " digit_count"}, 32'(bus.digit_count), 32'(c));
        check({tag, " err"},         32'(bus.err),         32'(e));
        check({tag, " value_valid"}, 32'(bus.value_valid), 32'(vv));
        check({tag, " value"},       32'(bus.value),       32'(val));
        check({tag, " char_ready"},  32'(bus.char_ready),  32'(cr));
    endtask

    // Drive inputs just after an edge, let one edge pass, then sample.
    task automatic drive(input logic [7:0] ch, input logic valid, input logic vready);
        bus.char_in     = ch;
        bus.char_valid  = valid;
        bus.value_ready = vready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.char_valid  = 1'b0;
        bus.value_ready = 1'b0;
        @(posedge clk);
        #1;
        check_all("in_reset", '0, 4'd0, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        check("after_reset char_ready", 32'(bus.char_ready), 32'd1);
    endtask

    initial begin
        bus.char_in     = 8'h00;
        bus.char_valid  = 1'b0;
        bus.value_ready = 1'b0;

        // Test 1: '1','a','F','3', Enter, then handshake.
        vecs.push_back(v(8'h31, 1, 0, 16'h0001, 1, 0, 0, 16'h0000, 1));
        vecs.push_back(v(8'h61, 1, 0, 16'h001A, 2, 0, 0, 16'h0000, 1));
        vecs.push_back(v(8'h46, 1, 0, 16'h01AF, 3, 0, 0, 16'h0000, 1));
        vecs.push_back(v(8'h33, 1, 0, 16'h1AF3, 4, 0, 0, 16'h0000, 1));
        vecs.push_back(v(8'h0D, 1, 0, 16'h0000, 0, 0, 1, 16'h1AF3, 0));
        vecs.push_back(v(8'h00, 0, 1, 16'h0000, 0, 0, 0, 16'h1AF3, 1));
        // Test 2: overflow on fifth digit, then Escape.
        vecs.push_back(v(8'h31, 1, 0, 16'h0001, 1, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h32, 1, 0, 16'h0012, 2, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h33, 1, 0, 16'h0123, 3, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h34, 1, 0, 16'h1234, 4, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h35, 1, 0, 16'h1234, 4, 1, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h00, 0, 0, 16'h1234, 4, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h1B, 1, 0, 16'h0000, 0, 0, 0, 16'h1AF3, 1));
        // Test 3: backspace mid-entry, commit 0079, backspace when empty.
        vecs.push_back(v(8'h37, 1, 0, 16'h0007, 1, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h38, 1, 0, 16'h0078, 2, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h08, 1, 0, 16'h0007, 1, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h39, 1, 0, 16'h0079, 2, 0, 0, 16'h1AF3, 1));
        vecs.push_back(v(8'h0D, 1, 1, 16'h0000, 0, 0, 1, 16'h0079, 0));
        vecs.push_back(v(8'h00, 0, 1, 16'h0000, 0, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h08, 1, 0, 16'h0000, 0, 0, 0, 16'h0079, 1));
        // Test 4: Enter when empty, bad chars, idle char not accepted.
        vecs.push_back(v(8'h0D, 1, 0, 16'h0000, 0, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h35, 1, 0, 16'h0005, 1, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h67, 1, 0, 16'h0005, 1, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h31, 0, 0, 16'h0005, 1, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h1B, 1, 0, 16'h0000, 0, 0, 0, 16'h0079, 1));
        // Mixed-case digits and range boundaries.
        vecs.push_back(v(8'h41, 1, 0, 16'h000A, 1, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h62, 1, 0, 16'h00AB, 2, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h63, 1, 0, 16'h0ABC, 3, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h44, 1, 0, 16'hABCD, 4, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h1B, 1, 0, 16'h0000, 0, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h65, 1, 0, 16'h000E, 1, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h66, 1, 0, 16'h00EF, 2, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h40, 1, 0, 16'h00EF, 2, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h47, 1, 0, 16'h00EF, 2, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h2F, 1, 0, 16'h00EF, 2, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h3A, 1, 0, 16'h00EF, 2, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h60, 1, 0, 16'h00EF, 2, 1, 0, 16'h0079, 1));
        vecs.push_back(v(8'h1B, 1, 0, 16'h0000, 0, 0, 0, 16'h0079, 1));
        // Leading zero counts as a digit: "0" Enter commits 0.
        vecs.push_back(v(8'h30, 1, 0, 16'h0000, 1, 0, 0, 16'h0079, 1));
        vecs.push_back(v(8'h0D, 1, 1, 16'h0000, 0, 0, 1, 16'h0000, 0));
        vecs.push_back(v(8'h00, 0, 1, 16'h0000, 0, 0, 0, 16'h0000, 1));

        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].ch, vecs[i].valid, vecs[i].vready);
            check_all($sformatf("vec%0d", i), vecs[i].exp_partial, vecs[i].exp_count,
                      vecs[i].exp_err, vecs[i].exp_vv, vecs[i].exp_value, vecs[i].exp_cr);
        end

        // Test 5: commit 00AB and hold it under back-pressure with chars offered.
        drive(8'h30, 1, 0);
        drive(8'h30, 1, 0);
        drive(8'h41, 1, 0);
        drive(8'h42, 1, 0);
        check("t5 partial before enter", 32'(bus.partial), 32'h00AB);
        drive(8'h0D, 1, 0);
        check_all("t5 commit", '0, 4'd0, 1'b0, 1'b1, 16'h00AB, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(8'h37, 1, 0);
            check_all($sformatf("t5 hold%0d", k), '0, 4'd0, 1'b0, 1'b1, 16'h00AB, 1'b0);
        end
        drive(8'h00, 0, 1);
        check_all("t5 release", '0, 4'd0, 1'b0, 1'b0, 16'h00AB, 1'b1);

        // Test 6a: reset mid-entry.
        drive(8'h35, 1, 0);
        drive(8'h36, 1, 0);
        check("t6 partial pre-reset", 32'(bus.partial), 32'h0056);
        bus.char_valid = 1'b0;
        do_reset();

        // Test 6b: reset while holding a committed value discards it.
        drive(8'h31, 1, 0);
        drive(8'h32, 1, 0);
        drive(8'h0D, 1, 0);
        check_all("t6 hold", '0, 4'd0, 1'b0, 1'b1, 16'h0012, 1'b0);
        do_reset();
        drive(8'h33, 1, 0);
        check_all("t6 post", 16'h0003, 4'd1, 1'b0, 1'b0, 16'h0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
